serial_tx_arbiter: RTL and testbench



---
 rtl/serial_tx_arbiter.sv | 118 +++++++++++
 tb/tb_serial_tx_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one MSB-first serial shift-out channel.
// Optional even-parity trailer bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             grant_id,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int CW = $clog2(SW);
  localparam logic [CW-1:0] CNT_INIT = CW'(SW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic            sdo_valid_q, busy_q, done_q;

  // Handshake rule: a word moves when reqN_valid && reqN_ready; ready is only
  // offered in IDLE, to the single arbitration winner, and never during reset.
  logic            any_valid, win, handshake;
  logic [WIDTH-1:0] win_data;
  logic [SW-1:0]   load_word;

  assign any_valid = req0_valid | req1_valid;
  assign win       = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign win_data  = win ? req1_data : req0_data;
  assign req0_ready = (state_q == IDLE) & ~reset & any_valid & ~win;
  assign req1_ready = (state_q == IDLE) & ~reset & any_valid & win;
  assign handshake  = req0_ready | req1_ready;

`ifdef SERIAL_TX_PARITY_EN
  assign load_word = {win_data, ^win_data};
`else
  assign load_word = win_data;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          shreg_d = load_word;
          grant_d = win;
          last_d  = win;
          cnt_d   = CNT_INIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Zero fill leaves the register clear, so sdo idles low in GAP/IDLE.
        shreg_d = {shreg_q[SW-2:0], 1'b0};
        if (cnt_q == '0) state_d = GAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      sdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      sdo_valid_q <= (state_d == SHIFT);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == GAP);
    end
  end

  assign sdo         = shreg_q[SW-1];
  assign sdo_valid   = sdo_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign grant_id    = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (WIDTH=4): single word, back-to-back
// grants, ignored mid-frame valids, reset mid-frame and round-robin contention.
module tb_serial_tx_arbiter;
  localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         sdo, sdo_valid, grant_id, busy, done;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  serial_tx_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sdo(sdo), .sdo_valid(sdo_valid), .grant_id(grant_id),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks readiness in the current IDLE cycle, then lets the handshake edge pass.
  task automatic do_hs(input logic e0, input logic e1);
    #1;
    check("ready0_hs", req0_ready, e0);
    check("ready1_hs", req1_ready, e1);
    tick();
  endtask

  // Pops the expected word and follows the frame from T+1 to the IDLE cycle after GAP.
  // pulse1 raises req1_valid during two mid-frame cycles to prove it is ignored.
  task automatic run_frame(input logic exp_id, input logic pulse1);
    logic [W-1:0] word;
    logic [NB-1:0] bits;
    word = exp_q.pop_front();
`ifdef SERIAL_TX_PARITY_EN
    bits = {word, ^word};
`else
    bits = word;
`endif
    for (int i = 0; i < NB; i++) begin
      if (pulse1) req1_valid = (i == 1 || i == 2);
      #1;
      check("sdo_bit", sdo, bits[NB-1-i]);
      check("sdo_valid", sdo_valid, 1'b1);
      check("busy_shift", busy, 1'b1);
      check("done_shift", done, 1'b0);
      check("grant_id", grant_id, exp_id);
      check("ready0_shift", req0_ready, 1'b0);
      check("ready1_shift", req1_ready, 1'b0);
      tick();
    end
    if (pulse1) req1_valid = 1'b0;
    #1;
    check("done_gap", done, 1'b1);
    check("busy_gap", busy, 1'b1);
    check("sdo_valid_gap", sdo_valid, 1'b0);
    check("sdo_gap", sdo, 1'b0);
    tick();
    check("busy_idle", busy, 1'b0);
    check("done_idle", done, 1'b0);
    check("grant_hold", grant_id, exp_id);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    tick();
    tick();
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_sdo", sdo, 1'b0);
    check("rst_sdo_valid", sdo_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_grant", grant_id, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    req0_valid = 1'b0;
    tick();
    check("idle_sdo", sdo, 1'b0);
    check("idle_ready0", req0_ready, 1'b0);

    // single word from requester 0
    req0_valid = 1'b1; req0_data = 4'b1011; exp_q.push_back(4'b1011);
    do_hs(1'b1, 1'b0);
    req0_valid = 1'b0;
    run_frame(1'b0, 1'b0);

    // requester 1 alone, then held valid: back-to-back grants with no wait
    req1_valid = 1'b1; req1_data = 4'b0101; exp_q.push_back(4'b0101);
    do_hs(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);
    req1_data = 4'b0011; exp_q.push_back(4'b0011);
    do_hs(1'b0, 1'b1);
    req1_valid = 1'b0;
    run_frame(1'b1, 1'b0);

    // req1_valid pulses only inside SHIFT and must leave no trace
    req0_valid = 1'b1; req0_data = 4'b1100; exp_q.push_back(4'b1100);
    do_hs(1'b1, 1'b0);
    req0_valid = 1'b0;
    run_frame(1'b0, 1'b1);
    check("pulse_ready1", req1_ready, 1'b0);
    tick();
    check("pulse_no_frame_valid", sdo_valid, 1'b0);
    check("pulse_no_frame_busy", busy, 1'b0);

    // reset asserted in cycle T+2 of a frame
    req1_valid = 1'b1; req1_data = 4'b1111;
    do_hs(1'b0, 1'b1);
    req1_valid = 1'b0;
    check("mid_sdo_t1", sdo, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_sdo", sdo, 1'b0);
    check("mid_rst_valid", sdo_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_grant", grant_id, 1'b0);
    check("mid_rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    tick();
    check("mid_rst_no_done", done, 1'b0);
    check("mid_rst_idle", busy, 1'b0);

    // continuous contention: requester 0 first after reset, then alternate
    req0_valid = 1'b1; req0_data = 4'hA;
    req1_valid = 1'b1; req1_data = 4'h5;
    exp_q.push_back(4'hA); exp_q.push_back(4'h5); exp_q.push_back(4'hA);
    do_hs(1'b1, 1'b0);
    run_frame(1'b0, 1'b0);
    do_hs(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);
    do_hs(1'b1, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    run_frame(1'b0, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
